// File: rtl/tmr_capture.sv
// Input-capture timer: a free-running counter is latched into CAP on a selected
// edge of the synchronized cap_in; byte registers CNT, CAP, CTRL, STAT on a simple bus.
module tmr_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] rdata,
    input  logic             cap_in,
    output logic             irq
);

    localparam logic [1:0] A_CNT  = 2'd0;
    localparam logic [1:0] A_CAP  = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       cap_q, cap_d;
    logic [3:0]             ctrl_q, ctrl_d;   // {EN, EDGE, BOTH, IE}
    logic [2:0]             stat_q, stat_d;   // {WRAP, OVR, CAPF}
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    logic en, edge_sel, both, ie;
    logic rise, fall, hit;
    logic cnt_wr, wrap_hit;
    logic [2:0] stat_clr, stat_set;

    always_comb begin
        en       = ctrl_q[3];
        edge_sel = ctrl_q[2];
        both     = ctrl_q[1];
        ie       = ctrl_q[0];

        // Synchronizer and delay flop run independently of EN.
        sync_d = {sync_q[SYNC_STAGES-2:0], cap_in};
        dly_d  = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~dly_q;
        fall   = ~sync_q[SYNC_STAGES-1] & dly_q;
        hit    = en & (both ? (rise | fall) : (edge_sel ? fall : rise));

        cnt_wr   = we && (addr == A_CNT);
        wrap_hit = en && !cnt_wr && (cnt_q == {WIDTH{1'b1}});

        cnt_d = cnt_q;
        if (cnt_wr) begin
            cnt_d = wdata;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        cap_d = hit ? cnt_q : cap_q;

        ctrl_d = ctrl_q;
        if (we && (addr == A_CTRL)) begin
            ctrl_d = wdata[7:4];
        end

        // Hardware set wins over a software write-1-to-clear in the same cycle.
        stat_clr = (we && (addr == A_STAT)) ? wdata[2:0] : 3'b000;
        stat_set = {wrap_hit, hit & stat_q[0], hit};
        stat_d   = (stat_q & ~stat_clr) | stat_set;

        rdata_d = rdata_q;
        if (re) begin
            case (addr)
                A_CNT:   rdata_d = cnt_q;
                A_CAP:   rdata_d = cap_q;
                A_CTRL:  rdata_d = WIDTH'({ctrl_q, 4'b0000});
                default: rdata_d = WIDTH'(stat_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            cap_q   <= '0;
            ctrl_q  <= '0;
            stat_q  <= '0;
            rdata_q <= '0;
            sync_q  <= '0;
            dly_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            ctrl_q  <= ctrl_d;
            stat_q  <= stat_d;
            rdata_q <= rdata_d;
            sync_q  <= sync_d;
            dly_q   <= dly_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = ie & (stat_q[0] | stat_q[1]);

endmodule

// File: tb/tb_tmr_capture.sv
// Bench for tmr_capture: register reads are scoreboarded through exp_q,
// irq and held-rdata checks go straight to check_eq.
module tb_tmr_capture;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   addr;
  logic [W-1:0] wdata;
  logic         we;
  logic         re;
  logic [W-1:0] rdata;
  logic         cap_in;
  logic         irq;

  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  tmr_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .cap_in(cap_in),
    .irq   (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // driver tasks: every call starts and ends 1 time unit after a rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    addr = a; re = 1'b1;
    tick(1);
    re = 1'b0;
    check_eq(tag, rdata, exp_q.pop_front());
  endtask

  task automatic rdwr(input string tag, input logic [1:0] a, input logic [W-1:0] d,
                      input logic [W-1:0] exp);
    exp_q.push_back(exp);
    addr = a; wdata = d; we = 1'b1; re = 1'b1;
    tick(1);
    we = 1'b0; re = 1'b0;
    check_eq(tag, rdata, exp_q.pop_front());
  endtask

  // Load CNT=v and change cap_in right after: the capture then latches v+2.
  task automatic cap_at(input logic [W-1:0] v, input logic lvl);
    wr(2'd0, v);
    cap_in = lvl;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0; cap_in = 1'b1;
    tick(2);
    rst = 1'b0;
    check_eq("rst_irq", {7'b0, irq}, 8'h00);
    rd("rst_cnt",  2'd0, 8'h00);
    rd("rst_cap",  2'd1, 8'h00);
    rd("rst_ctrl", 2'd2, 8'h00);
    rd("rst_stat", 2'd3, 8'h00);
    check_eq("rst_irq2", {7'b0, irq}, 8'h00);

    // rising capture: cap_in first sampled at the edge where CNT was 0x20
    cap_in = 1'b0;
    tick(4);
    wr(2'd0, 8'h10);
    wr(2'd2, 8'h90);
    tick(16);
    cap_in = 1'b1;
    tick(2);
    check_eq("irq_before_cap", {7'b0, irq}, 8'h00);
    tick(1);
    check_eq("irq_after_cap", {7'b0, irq}, 8'h01);
    rd("rise_cap",  2'd1, 8'h22);
    rd("rise_stat", 2'd3, 8'h01);
    wr(2'd3, 8'h01);
    rd("rise_clr", 2'd3, 8'h00);
    check_eq("irq_clr", {7'b0, irq}, 8'h00);

    // falling-edge select
    cap_in = 1'b0;
    tick(5);
    wr(2'd2, 8'hC0);
    cap_in = 1'b1;
    tick(5);
    rd("fall_norise", 2'd3, 8'h00);
    cap_at(8'h40, 1'b0);
    tick(4);
    rd("fall_cap",  2'd1, 8'h42);
    rd("fall_stat", 2'd3, 8'h01);

    // both edges, second capture sets OVR
    wr(2'd3, 8'h07);
    wr(2'd2, 8'hA0);
    cap_at(8'h50, 1'b1);
    tick(5);
    rd("both_cap1", 2'd1, 8'h52);
    cap_at(8'h60, 1'b0);
    tick(5);
    rd("both_cap2", 2'd1, 8'h62);
    rd("both_stat", 2'd3, 8'h03);
    check_eq("both_irq_ie0", {7'b0, irq}, 8'h00);

    // overflow and clear
    wr(2'd3, 8'h07);
    wr(2'd2, 8'h90);
    cap_at(8'h30, 1'b1);
    tick(4);
    cap_in = 1'b0;
    tick(5);
    cap_at(8'h70, 1'b1);
    tick(5);
    rd("ovr_cap",  2'd1, 8'h72);
    rd("ovr_stat", 2'd3, 8'h03);
    check_eq("ovr_irq", {7'b0, irq}, 8'h01);
    wr(2'd3, 8'h03);
    rd("ovr_clr", 2'd3, 8'h00);
    check_eq("ovr_irq_clr", {7'b0, irq}, 8'h00);

    // wrap
    wr(2'd0, 8'hFE);
    tick(2);
    rd("wrap_cnt",  2'd0, 8'h00);
    rd("wrap_stat", 2'd3, 8'h04);
    wr(2'd3, 8'h04);
    rd("wrap_clr", 2'd3, 8'h00);
    wr(2'd0, 8'hFF);
    wr(2'd3, 8'h04);
    rd("wrap_set_wins", 2'd3, 8'h04);
    wr(2'd3, 8'h04);
    wr(2'd0, 8'h33);
    rd("cnt_wr_wins", 2'd0, 8'h33);
    wr(2'd2, 8'h8F);
    rd("ctrl_low_bits", 2'd2, 8'h80);
    wr(2'd2, 8'h00);
    wr(2'd0, 8'hFF);
    tick(3);
    rd("en0_cnt_hold", 2'd0, 8'hFF);
    rd("en0_no_wrap",  2'd3, 8'h00);
    rdwr("rdwr_prewrite", 2'd0, 8'h12, 8'hFF);
    rd("rdwr_post", 2'd0, 8'h12);
    tick(2);
    check_eq("rdata_hold", rdata, 8'h12);
    wr(2'd1, 8'hAA);
    rd("cap_readonly", 2'd1, 8'h72);

    // capture coinciding with a CAPF clear
    wr(2'd3, 8'h07);
    wr(2'd2, 8'h90);
    cap_in = 1'b0;
    tick(5);
    cap_at(8'h20, 1'b1);
    tick(2);
    wr(2'd3, 8'h01);
    rd("sim_cap",  2'd1, 8'h22);
    rd("sim_stat", 2'd3, 8'h01);

    // reset mid-capture discards the pending edge
    cap_in = 1'b0;
    tick(5);
    cap_at(8'h10, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
    rd("midrst_cap",  2'd1, 8'h00);
    rd("midrst_stat", 2'd3, 8'h00);
    check_eq("midrst_irq", {7'b0, irq}, 8'h00);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_capture.md
Name: tmr_capture

Overview:
- 8-bit input-capture timer peripheral on the SoC CPU register bus.
- Complements the compare/period timer: where that block generates timing events, this block measures them.
- A free-running counter is latched into a capture register on a selected edge of the external input cap_in; status flags and an interrupt are raised.
- Software accesses four byte-wide registers through addr/wdata/we/re/rdata.

Parameters:
- WIDTH, 8, width of the counter, the capture register and the data bus.
- SYNC_STAGES, 2, number of synchronizer flops on cap_in (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- addr  input  2  register select: 0 CNT, 1 CAP, 2 CTRL, 3 STAT
- wdata  input  WIDTH  write data
- we  input  1  write strobe, sampled on clk
- re  input  1  read strobe, sampled on clk
- rdata  output  WIDTH  registered read data
- cap_in  input  1  asynchronous external capture input
- irq  output  1  interrupt request, active-high level

Behaviour:
- Reset: synchronous, active-high. When rst=1 at a clk edge, all of the following clear to 0: CNT, CAP, CTRL, STAT, rdata, and all synchronizer and edge flops. irq is 0. Reset mid-capture discards the pending edge.
- CTRL bit fields:
  - bit7 EN: counter enable and capture enable.
  - bit6 EDGE: 0 = rising, 1 = falling.
  - bit5 BOTH: capture on either edge; overrides EDGE.
  - bit4 IE: interrupt enable.
  - bits3:0: read as 0; writes ignored.
- STAT bit fields (write-1-to-clear; writing 0 has no effect; bits7:3 read as 0):
  - bit0 CAPF: capture occurred.
  - bit1 OVR: capture occurred while CAPF was already 1.
  - bit2 WRAP: counter wrapped from 0xFF to 0x00.
- CAP is read-only; writes to it are ignored.
- CNT:
  - When EN=1, CNT increments by 1 every clk, modulo 2^WIDTH.
  - The 0xFF->0x00 increment sets WRAP. A software write of any value never sets WRAP.
  - A CPU write to CNT takes priority over the increment in the same cycle; CNT = wdata on the next cycle.
- Synchronizer and edge detect:
  - cap_in passes through SYNC_STAGES flops, then one delay flop.
  - Edge detection compares the last sync stage against the delay flop.
  - These flops run regardless of EN.
- Capture timing:
  - Let E0 be the first clk edge that samples cap_in at its new level.
  - With SYNC_STAGES=2, capture occurs at edge E0+2.
  - CAP receives the CNT value held before E0+2's increment, i.e. CNT-before-E0 plus 2 when counting continuously.
  - No capture occurs when EN=0, or when the edge does not match EDGE/BOTH.
- Capture side effects:
  - On capture, CAPF is set to 1.
  - If CAPF was already 1, CAP is still overwritten and OVR is set.
- Simultaneous events:
  - A capture and a W1C of CAPF in the same cycle: CAPF remains 1.
  - A wrap and a W1C of WRAP in the same cycle: WRAP remains 1.
  - Set always beats clear.
- Reads:
  - When re=1 at edge E, rdata equals the addressed register value as it stood before E, and is valid after E.
  - rdata holds its value when re=0.
  - Reads have no side effects.
  - If we and re are both 1, rdata returns the pre-write value.
- irq = IE & (CAPF | OVR), decoded from flops with no added latency.
- Post-reset corner case: because the synchronizer resets to 0, a cap_in held high through reset produces a rising-edge event 2 edges after reset deasserts. This is captured only if EN has been set by then.

Test Plan:
- Reset: drive rst=1 for 2 cycles with cap_in=1, then read all four addresses -> every read returns 0x00; irq=0.
- Rising capture:
  - Stimulus: write CNT=0x10, then CTRL=0x90; raise cap_in so that it is first sampled at the edge where CNT was 0x20.
  - Required: CAP=0x22; STAT=0x01; irq=1 from the cycle after the capture edge.
  - Then write STAT=0x01 -> STAT=0x00 and irq=0.
- Edge select:
  - CTRL=0xC0: a rising edge on cap_in gives no capture (STAT=0); a falling edge captures.
  - CTRL=0xA0: both a rise and a fall capture -> second capture sets OVR; STAT=0x03.
- Overflow and clear: two rising captures 10 cycles apart with no clear in between -> CAP holds the second value and STAT=0x03; write STAT=0x03 -> STAT=0x00.
- Wrap:
  - Write CNT=0xFE with EN=1 -> after 2 increments CNT=0x00 and WRAP=1.
  - Write CNT=0xFF while EN=0 -> WRAP unchanged.
  - A CNT write in the same cycle as an increment -> CNT equals wdata.
- Simultaneous set/clear: issue the STAT=0x01 write in the same cycle as a capture -> CAPF stays 1 and CAP is updated.
